modbus_rsp_framer: RTL and testbench

//  Response-side framer of the Modbus RTU slave: consumes handler_done plus response descriptor from function handler,

---
 rtl/modbus_rsp_framer_if.sv | 29 ++
 rtl/modbus_rsp_framer.sv | 164 ++++++++++++++++
 tb/tb_modbus_rsp_framer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/modbus_rsp_framer_if.sv
// modbus_rsp_framer_if: descriptor, DPRAM read, UART TX and status signals of the response framer
interface modbus_rsp_framer_if;
    logic        handler_done;
    logic [7:0]  dev_addr;
    logic [7:0]  func_code;
    logic [15:0] addr;
    logic [15:0] data;
    logic [7:0]  tx_quantity;
    logic [7:0]  exception_code;
    logic        dpram_ren;
    logic [7:0]  dpram_raddr;
    logic [15:0] dpram_rdata;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        busy;
    logic        frame_done;
    logic        drop_err;
    modport slave (
        input  handler_done, dev_addr, func_code, addr, data, tx_quantity, exception_code,
        input  dpram_rdata, tx_done,
        output dpram_ren, dpram_raddr, tx_start, tx_data, busy, frame_done, drop_err
    );
    modport master (
        output handler_done, dev_addr, func_code, addr, data, tx_quantity, exception_code,
        output dpram_rdata, tx_done,
        input  dpram_ren, dpram_raddr, tx_start, tx_data, busy, frame_done, drop_err
    );
endinterface

// File: rtl/modbus_rsp_framer.sv
// modbus_rsp_framer: builds a Modbus RTU reply with CRC16, streams it to the UART, then holds the 3.5-char silence
module modbus_rsp_framer #(
    parameter int T35_CYCLES = 200000,
    parameter int GAP_W      = 18
) (
    input  logic clk,
    input  logic rst_n,
    modbus_rsp_framer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, HDR, FETCH, DATA_HI, DATA_LO, CRC_LO, CRC_HI, GAP} state_t;
    state_t            r_state;
    logic              r_wait;
    logic [1:0]        r_ph;
    logic [2:0]        r_idx;
    logic [7:0]        r_word;
    logic [15:0]       r_rdata;
    logic [15:0]       r_crc;
    logic [GAP_W-1:0]  r_gap;
    logic [7:0]        r_dev, r_func, r_qty, r_exc;
    logic [15:0]       r_addr, r_data;
    logic              r_tx_start, r_ren, r_busy, r_frame_done, r_drop_err;
    logic [7:0]        r_tx_data, r_raddr;
    logic              w_is_exc, w_is_rd, w_is_wr, w_valid, w_to_crc, w_byte_state, w_crc_state;
    logic [2:0]        w_hdr_last;
    logic [7:0]        w_hdr_byte, w_tx_byte;
    logic [15:0]       w_crc_next;
    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] x;
        x = c ^ {8'h00, b};
        for (int k = 0; k < 8; k++) x = x[0] ? ((x >> 1) ^ 16'hA001) : (x >> 1);
        return x;
    endfunction
    assign bus.tx_start    = r_tx_start;
    assign bus.tx_data     = r_tx_data;
    assign bus.dpram_ren   = r_ren;
    assign bus.dpram_raddr = r_raddr;
    assign bus.busy        = r_busy;
    assign bus.frame_done  = r_frame_done;
    assign bus.drop_err    = r_drop_err;
    always_comb begin
        w_is_exc     = r_exc != 8'h00;
        w_is_rd      = (r_func == 8'h03) || (r_func == 8'h04);
        w_is_wr      = r_func == 8'h06;
        w_valid      = w_is_exc || w_is_rd || w_is_wr;
        w_to_crc     = w_is_exc || w_is_wr || (r_qty == 8'h00);
        w_hdr_last   = (w_is_wr && !w_is_exc) ? 3'd5 : 3'd2;
        w_hdr_byte   = r_idx == 3'd0 ? r_dev :
                       w_is_exc ? (r_idx == 3'd1 ? (r_func | 8'h80) : r_exc) :
                       r_idx == 3'd1 ? r_func :
                       w_is_rd ? {r_qty[6:0], 1'b0} :
                       r_idx == 3'd2 ? r_addr[15:8] :
                       r_idx == 3'd3 ? r_addr[7:0] :
                       r_idx == 3'd4 ? r_data[15:8] : r_data[7:0];
        w_tx_byte    = r_state == HDR ? w_hdr_byte :
                       r_state == DATA_HI ? r_rdata[15:8] :
                       r_state == DATA_LO ? r_rdata[7:0] :
                       r_state == CRC_LO ? r_crc[7:0] : r_crc[15:8];
        w_crc_state  = (r_state == CRC_LO) || (r_state == CRC_HI);
        w_byte_state = (r_state == HDR) || (r_state == DATA_HI) || (r_state == DATA_LO) || w_crc_state;
        w_crc_next   = crc16_step(r_crc, w_tx_byte);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_wait       <= 1'b0;
            r_ph         <= 2'd0;
            r_idx        <= 3'd0;
            r_word       <= 8'h00;
            r_rdata      <= 16'h0000;
            r_crc        <= 16'hFFFF;
            r_gap        <= '0;
            r_dev        <= 8'h00;
            r_func       <= 8'h00;
            r_qty        <= 8'h00;
            r_exc        <= 8'h00;
            r_addr       <= 16'h0000;
            r_data       <= 16'h0000;
            r_tx_start   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_ren        <= 1'b0;
            r_raddr      <= 8'h00;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_drop_err   <= 1'b0;
        end else begin
            r_tx_start   <= 1'b0;
            r_ren        <= 1'b0;
            r_frame_done <= 1'b0;
            r_drop_err   <= bus.handler_done && (r_state != IDLE);
            // Every byte state first issues its byte, then waits in place for tx_done
            if (w_byte_state && w_valid && !r_wait) begin
                r_tx_start <= 1'b1;
                r_tx_data  <= w_tx_byte;
                r_wait     <= 1'b1;
                if (!w_crc_state) r_crc <= w_crc_next;
            end
            case (r_state)
                IDLE: if (bus.handler_done) begin
                    r_dev   <= bus.dev_addr;
                    r_func  <= bus.func_code;
                    r_addr  <= bus.addr;
                    r_data  <= bus.data;
                    r_qty   <= bus.tx_quantity;
                    r_exc   <= bus.exception_code;
                    r_crc   <= 16'hFFFF;
                    r_idx   <= 3'd0;
                    r_wait  <= 1'b0;
                    r_busy  <= 1'b1;
                    r_state <= HDR;
                end
                HDR: if (!w_valid) begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end else if (r_wait && bus.tx_done) begin
                    r_wait <= 1'b0;
                    if (r_idx == w_hdr_last) begin
                        r_word  <= 8'h00;
                        r_ph    <= 2'd0;
                        r_state <= w_to_crc ? CRC_LO : FETCH;
                    end else r_idx <= r_idx + 3'd1;
                end
                // ren in phase 0, RAM registers during phase 1, word captured in phase 2
                FETCH: begin
                    r_ph <= r_ph + 2'd1;
                    if (r_ph == 2'd0) begin
                        r_ren   <= 1'b1;
                        r_raddr <= r_word;
                    end else if (r_ph == 2'd2) begin
                        r_rdata <= bus.dpram_rdata;
                        r_ph    <= 2'd0;
                        r_state <= DATA_HI;
                    end
                end
                DATA_HI: if (r_wait && bus.tx_done) begin
                    r_wait  <= 1'b0;
                    r_state <= DATA_LO;
                end
                DATA_LO: if (r_wait && bus.tx_done) begin
                    r_wait <= 1'b0;
                    if (r_word == r_qty - 8'd1) r_state <= CRC_LO;
                    else begin
                        r_word  <= r_word + 8'd1;
                        r_state <= FETCH;
                    end
                end
                CRC_LO: if (r_wait && bus.tx_done) begin
                    r_wait  <= 1'b0;
                    r_state <= CRC_HI;
                end
                CRC_HI: if (r_wait && bus.tx_done) begin
                    r_wait  <= 1'b0;
                    r_gap   <= GAP_W'(1);
                    r_state <= GAP;
                end
                GAP: if (r_gap == GAP_W'(T35_CYCLES - 1)) begin
                    r_frame_done <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end else r_gap <= r_gap + GAP_W'(1);
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_modbus_rsp_framer.sv
// tb_modbus_rsp_framer: directed frames checked against a byte scoreboard fed at stimulus time
module tb_modbus_rsp_framer;
    localparam int T35 = 40;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    modbus_rsp_framer_if bus();
    modbus_rsp_framer #(.T35_CYCLES(T35), .GAP_W(18)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    logic [15:0] mem [0:255];
    logic [7:0]  exp_q [$];
    logic [7:0]  raddr_q [$];
    int n_cmp = 0, n_err = 0;
    int cyc = 0, bytes_seen = 0, hold_at = -1, done_cnt = 0;
    int last_done_cyc = 0, fd_cyc = 0, frames = 0, drops = 0;
    always @(posedge clk) if (bus.dpram_ren) bus.dpram_rdata <= mem[bus.dpram_raddr];
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask
    function automatic logic [15:0] ref_crc(input logic [7:0] b [$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (b[i]) begin
            c = c ^ {8'h00, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction
    task automatic push_bytes(input logic [7:0] b [$], input bit add_crc);
        logic [15:0] c;
        c = ref_crc(b);
        foreach (b[i]) exp_q.push_back(b[i]);
        if (add_crc) begin
            exp_q.push_back(c[7:0]);
            exp_q.push_back(c[15:8]);
        end
    endtask
    task automatic send(input logic [7:0] dev, input logic [7:0] func, input logic [15:0] a,
                        input logic [15:0] d, input logic [7:0] q, input logic [7:0] exc);
        bus.dev_addr = dev;
        bus.func_code = func;
        bus.addr = a;
        bus.data = d;
        bus.tx_quantity = q;
        bus.exception_code = exc;
        bus.handler_done = 1'b1;
        @(negedge clk);
        bus.handler_done = 1'b0;
    endtask
    task automatic wait_idle(input int lim);
        int k;
        k = 0;
        while (bus.busy && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", 32'(bus.busy), 32'd0);
    endtask
    task automatic wait_bytes(input int n, input int lim);
        int k;
        k = 0;
        while (bytes_seen < n && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("bytes_timeout", 32'(bytes_seen >= n), 32'd1);
    endtask
    // UART responder and output monitor share one process so tx_done timing is deterministic
    initial begin : monitor
        logic [8:0] e;
        bus.tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus.tx_done = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    bus.tx_done = 1'b1;
                    last_done_cyc = cyc;
                end
            end
            if (bus.tx_start) begin
                if (exp_q.size() > 0) e = {1'b0, exp_q.pop_front()};
                else e = 9'h100;
                chk("tx_byte", 32'({1'b0, bus.tx_data}), 32'(e));
                bytes_seen++;
                if (bytes_seen != hold_at) done_cnt = 4;
            end
            if (bus.dpram_ren) begin
                if (raddr_q.size() > 0) e = {1'b0, raddr_q.pop_front()};
                else e = 9'h100;
                chk("dpram_raddr", 32'({1'b0, bus.dpram_raddr}), 32'(e));
            end
            if (bus.frame_done) begin
                frames++;
                fd_cyc = cyc;
            end
            if (bus.drop_err) drops++;
        end
    end
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    initial begin : stim
        int base, bc;
        bus.handler_done = 1'b0;
        bus.dev_addr = 8'h00;
        bus.func_code = 8'h00;
        bus.addr = 16'h0000;
        bus.data = 16'h0000;
        bus.tx_quantity = 8'h00;
        bus.exception_code = 8'h00;
        bus.dpram_rdata = 16'h0000;
        foreach (mem[i]) mem[i] = 16'h0000;
        mem[0] = 16'h1234;
        mem[1] = 16'hABCD;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_tx_start", 32'(bus.tx_start), 0);
        chk("rst_tx_data", 32'(bus.tx_data), 0);
        chk("rst_ren", 32'(bus.dpram_ren), 0);
        chk("rst_frame_done", 32'(bus.frame_done), 0);
        chk("rst_drop_err", 32'(bus.drop_err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        // exception reply
        push_bytes('{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1}, 1'b0);
        send(8'h01, 8'h03, 16'h0000, 16'h0000, 8'h01, 8'h02);
        chk("busy_after_capture", 32'(bus.busy), 1);
        wait_idle(2000);
        chk("exc_frames", 32'(frames), 1);
        chk("exc_gap_len", 32'(fd_cyc - last_done_cyc), 32'(T35));
        chk("exc_q_left", 32'(exp_q.size()), 0);
        // write-single echo
        push_bytes('{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B}, 1'b0);
        send(8'h01, 8'h06, 16'h0001, 16'h0003, 8'h00, 8'h00);
        wait_idle(2000);
        chk("echo_frames", 32'(frames), 2);
        chk("echo_q_left", 32'(exp_q.size()), 0);
        // read input registers, two words
        push_bytes('{8'h01, 8'h04, 8'h04, 8'h12, 8'h34, 8'hAB, 8'hCD}, 1'b1);
        raddr_q.push_back(8'h00);
        raddr_q.push_back(8'h01);
        send(8'h01, 8'h04, 16'h0000, 16'h0000, 8'h02, 8'h00);
        wait_idle(2000);
        chk("rd2_frames", 32'(frames), 3);
        chk("rd2_q_left", 32'(exp_q.size()), 0);
        chk("rd2_raddr_left", 32'(raddr_q.size()), 0);
        // zero quantity: header plus CRC only, no DPRAM access
        push_bytes('{8'h01, 8'h03, 8'h00}, 1'b1);
        send(8'h01, 8'h03, 16'h0000, 16'h0000, 8'h00, 8'h00);
        wait_idle(2000);
        chk("qty0_frames", 32'(frames), 4);
        chk("qty0_q_left", 32'(exp_q.size()), 0);
        // unsupported function without exception: silent, busy for one cycle
        base = bytes_seen;
        send(8'h01, 8'h05, 16'h0000, 16'h0000, 8'h00, 8'h00);
        bc = 0;
        while (bus.busy && bc < 10) begin
            bc++;
            @(negedge clk);
        end
        repeat (T35 + 5) @(negedge clk);
        chk("f05_busy_cycles", 32'(bc), 1);
        chk("f05_no_bytes", 32'(bytes_seen - base), 0);
        chk("f05_no_frame", 32'(frames), 4);
        // drops during DATA_LO and during GAP leave the frame intact
        mem[0] = 16'h5678;
        base = bytes_seen;
        push_bytes('{8'h11, 8'h03, 8'h02, 8'h56, 8'h78}, 1'b1);
        raddr_q.push_back(8'h00);
        send(8'h11, 8'h03, 16'h0000, 16'h0000, 8'h01, 8'h00);
        wait_bytes(base + 5, 500);
        @(negedge clk);
        send(8'h01, 8'h06, 16'h0001, 16'h0003, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        chk("drop_in_data_lo", 32'(drops), 1);
        wait_bytes(base + 7, 500);
        repeat (10) @(negedge clk);
        chk("busy_in_gap", 32'(bus.busy), 1);
        send(8'h01, 8'h06, 16'h0001, 16'h0003, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        chk("drop_in_gap", 32'(drops), 2);
        wait_idle(2000);
        chk("drop_frames", 32'(frames), 5);
        chk("drop_q_left", 32'(exp_q.size()), 0);
        // reset while waiting tx_done of the third byte
        base = bytes_seen;
        hold_at = base + 3;
        push_bytes('{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B}, 1'b0);
        send(8'h01, 8'h06, 16'h0001, 16'h0003, 8'h00, 8'h00);
        wait_bytes(base + 3, 500);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_tx_start", 32'(bus.tx_start), 0);
        chk("mid_rst_tx_data", 32'(bus.tx_data), 0);
        chk("mid_rst_ren", 32'(bus.dpram_ren), 0);
        chk("mid_rst_raddr", 32'(bus.dpram_raddr), 0);
        chk("mid_rst_frame_done", 32'(bus.frame_done), 0);
        chk("mid_rst_drop_err", 32'(bus.drop_err), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hold_at = -1;
        repeat (T35 + 5) @(negedge clk);
        chk("mid_rst_no_bytes", 32'(bytes_seen - base), 3);
        chk("mid_rst_no_frame", 32'(frames), 5);
        push_bytes('{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1}, 1'b0);
        send(8'h01, 8'h03, 16'h0000, 16'h0000, 8'h01, 8'h02);
        wait_idle(2000);
        chk("post_rst_frames", 32'(frames), 6);
        chk("post_rst_q_left", 32'(exp_q.size()), 0);
        chk("total_drops", 32'(drops), 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
